// File: rtl/acl_seq_pkg.sv
// Shared types and helpers for the ACL2 mode sequencer.
// States, fault counter limit and switch-pattern decode.
package acl_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT_REQ   = 3'd1,
        S_INIT_WAIT  = 3'd2,
        S_START_REQ  = 3'd3,
        S_START_DONE = 3'd4,
        S_RUN        = 3'd5,
        S_RESET_REQ  = 3'd6,
        S_FAULT      = 3'd7
    } t_acl_seq_state;

    localparam logic [7:0] c_acl_seq_fault_count_max = 8'd255;

    typedef struct packed {
        logic        valid;
        logic [31:0] onehot;
    } t_mode_pattern;

    // Valid: exactly one bit among the low mode_count bits, nothing above.
    function automatic t_mode_pattern valid_mode_pattern(
        input logic [31:0] switches,
        input int          mode_count
    );
        t_mode_pattern r;
        int            ones;
        logic          high;
        r.onehot = '0;
        ones     = 0;
        high     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < mode_count) begin
                r.onehot[i] = switches[i];
                if (switches[i]) ones++;
            end else if (switches[i]) begin
                high = 1'b1;
            end
        end
        r.valid = (ones == 1) && !high;
        return r;
    endfunction

endpackage

// File: rtl/acl_seq_watchdog.sv
// Handshake watchdog: counts enabled cycles, flags the last allowed one.
// Clearing on any state change restarts the window.
module acl_seq_watchdog #(
    parameter int PARM_TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int W = $clog2(PARM_TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(PARM_TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/acl_mode_sequencer.sv
// Switch-driven init/start sequencer for the PMOD ACL2 driver,
// with handshake watchdog, sticky fault and soft-reset on switch change.
module acl_mode_sequencer
    import acl_seq_pkg::*;
#(
    parameter int PARM_MODE_COUNT     = 2,
    parameter int PARM_SW_WIDTH       = 4,
    parameter int PARM_TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       i_clk_20mhz,
    input  logic                       i_rst_20mhz,
    input  logic                       i_acl_command_ready,
    input  logic [PARM_SW_WIDTH-1:0]   i_switches_debounced,
    output logic [PARM_MODE_COUNT-1:0] o_acl_cmd_init,
    output logic [PARM_MODE_COUNT-1:0] o_acl_cmd_start,
    output logic                       o_acl_cmd_soft_reset,
    output logic [PARM_MODE_COUNT-1:0] o_mode_onehot,
    output logic                       o_reading_inactive,
    output logic                       o_active_init_display,
    output logic                       o_active_run_display,
    output logic                       o_fault,
    output logic [7:0]                 o_fault_count
);

    t_acl_seq_state             state_q, state_d;
    logic [PARM_MODE_COUNT-1:0] mode_q, mode_d;
    logic [7:0]                 fcnt_q, fcnt_d;
    t_mode_pattern              pat;
    logic                       run_match;
    logic                       sw_zero;
    logic                       wd_en;
    logic                       wd_clear;
    logic                       wd_expired;

    assign pat       = valid_mode_pattern(32'(i_switches_debounced), PARM_MODE_COUNT);
    assign run_match = pat.valid && (pat.onehot == 32'(mode_q));
    assign sw_zero   = (i_switches_debounced == '0);
    assign wd_en     = (state_q == S_INIT_REQ) || (state_q == S_INIT_WAIT) ||
                       (state_q == S_START_REQ) || (state_q == S_RESET_REQ);
    assign wd_clear  = (state_d != state_q);

    acl_seq_watchdog #(
        .PARM_TIMEOUT_CYCLES(PARM_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (i_clk_20mhz),
        .rst_i     (i_rst_20mhz),
        .enable_i  (wd_en),
        .clear_i   (wd_clear),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_acl_command_ready && pat.valid) begin
                    state_d = S_INIT_REQ;
                    mode_d  = pat.onehot[PARM_MODE_COUNT-1:0];
                end
            end
            S_INIT_REQ:   if (!i_acl_command_ready) state_d = S_INIT_WAIT;
            S_INIT_WAIT:  if (i_acl_command_ready) state_d = S_START_REQ;
            S_START_REQ:  if (!i_acl_command_ready) state_d = S_START_DONE;
            S_START_DONE: state_d = S_RUN;
            S_RUN:        if (!run_match) state_d = S_RESET_REQ;
            S_RESET_REQ:  if (i_acl_command_ready) state_d = S_IDLE;
            S_FAULT: begin
                if (i_acl_command_ready && sw_zero) state_d = S_IDLE;
            end
            default:      state_d = S_IDLE;
        endcase
        // Timeout beats any handshake edge seen in the same cycle.
        if (wd_expired) state_d = S_FAULT;
        if (state_d == S_RESET_REQ || state_d == S_FAULT) mode_d = '0;
        if (state_d == S_FAULT && state_q != S_FAULT &&
            fcnt_q != c_acl_seq_fault_count_max) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign o_acl_cmd_init        = (state_q == S_INIT_REQ) ? mode_q : '0;
    assign o_acl_cmd_start       = (state_q == S_START_REQ) ? mode_q : '0;
    assign o_acl_cmd_soft_reset  = (state_q == S_RESET_REQ) || (state_q == S_FAULT);
    assign o_mode_onehot         = mode_q;
    assign o_reading_inactive    = (state_q == S_IDLE);
    assign o_active_init_display = (state_q == S_INIT_REQ) || (state_q == S_INIT_WAIT) ||
                                   (state_q == S_START_REQ) || (state_q == S_START_DONE);
    assign o_active_run_display  = (state_q == S_RUN);
    assign o_fault               = (state_q == S_FAULT);
    assign o_fault_count         = fcnt_q;

endmodule
